// File: rtl/permute_pipe.sv
// permute_pipe: elastic pipelined rotate-right of a DIM-bit hypervector, one log-shifter group per stage.
// Optional `PERMUTE_PIPE_INVERSE_EN adds in_inverse, which rotates left by in_shift instead.
module permute_pipe #(
  parameter int DIM            = 1024,
  parameter int SHIFT_W        = $clog2(DIM),
  parameter int BITS_PER_STAGE = 2,
  parameter int TAG_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIM-1:0]     in_data,
  input  logic [SHIFT_W-1:0] in_shift,
`ifdef PERMUTE_PIPE_INVERSE_EN
  input  logic               in_inverse,
`endif
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIM-1:0]     out_data,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int B      = BITS_PER_STAGE;
  localparam int NSTAGE = (SHIFT_W + B - 1) / B;
  logic [NSTAGE-1:0]  r_valid, w_ld, w_v;
  logic [DIM-1:0]     r_data [NSTAGE];
  logic [DIM-1:0]     w_d    [NSTAGE];
  logic [SHIFT_W-1:0] r_sh   [NSTAGE];
  logic [SHIFT_W-1:0] w_s    [NSTAGE];
  logic [TAG_W-1:0]   r_tag  [NSTAGE];
  logic [TAG_W-1:0]   w_t    [NSTAGE];
  logic [SHIFT_W-1:0] w_amt;
`ifdef PERMUTE_PIPE_INVERSE_EN
  assign w_amt = in_inverse ? SHIFT_W'(-in_shift) : in_shift;
`else
  assign w_amt = in_shift;
`endif
  function automatic logic [DIM-1:0] rotr(input logic [DIM-1:0] d, input logic [SHIFT_W-1:0] k);
    return DIM'({d, d} >> k);
  endfunction
  // Residual shift is kept right-aligned, so every stage consumes its chunk from the low B bits.
  // Stage s may load unless it and every stage after it are full while the output is stalled.
  always_comb begin
    w_v[0] = in_valid;
    w_d[0] = in_data;
    w_s[0] = w_amt;
    w_t[0] = in_tag;
    for (int s = 1; s < NSTAGE; s++) begin
      w_v[s] = r_valid[s-1];
      w_d[s] = r_data[s-1];
      w_s[s] = r_sh[s-1];
      w_t[s] = r_tag[s-1];
    end
    for (int s = 0; s < NSTAGE; s++)
      w_ld[s] = out_ready | ~&(r_valid | NSTAGE'((1 << s) - 1));
  end
  always_ff @(posedge clk) begin
    for (int s = 0; s < NSTAGE; s++)
      if (w_ld[s]) begin
        r_valid[s] <= w_v[s];
        r_data[s]  <= rotr(w_d[s], SHIFT_W'(w_s[s][B-1:0]) << (s * B));
        r_sh[s]    <= w_s[s] >> B;
        r_tag[s]   <= w_t[s];
      end
    if (rst) r_valid <= '0;
  end
  assign in_ready  = w_ld[0];
  assign out_valid = r_valid[NSTAGE-1];
  assign out_data  = r_data[NSTAGE-1];
  assign out_tag   = r_tag[NSTAGE-1];
endmodule

// File: tb/tb_permute_pipe.sv
// tb_permute_pipe: directed checks of permute_pipe at DIM=1024/B=2 and DIM=16/B=3.
module tb_permute_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int n_vec = 0;
  int n_err = 0;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [1023:0] a_in_data, a_out_data;
  logic [9:0]   a_in_shift;
  logic [7:0]   a_in_tag, a_out_tag;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0]  b_in_data, b_out_data;
  logic [3:0]   b_in_shift;
  logic [7:0]   b_in_tag, b_out_tag;
`ifdef PERMUTE_PIPE_INVERSE_EN
  logic a_in_inverse, b_in_inverse;
`endif
  permute_pipe #(.DIM(1024), .BITS_PER_STAGE(2), .TAG_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_shift(a_in_shift),
`ifdef PERMUTE_PIPE_INVERSE_EN
    .in_inverse(a_in_inverse),
`endif
    .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_tag(a_out_tag));
  permute_pipe #(.DIM(16), .BITS_PER_STAGE(3), .TAG_W(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_shift(b_in_shift),
`ifdef PERMUTE_PIPE_INVERSE_EN
    .in_inverse(b_in_inverse),
`endif
    .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_tag(b_out_tag));
  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h (low 64 bits)", tag, obs[63:0], exp[63:0]);
    end
  endtask
  function automatic logic [1023:0] rot_ref(input logic [1023:0] d, input int k);
    logic [1023:0] r;
    for (int i = 0; i < 1024; i++) r[i] = d[(i + k) % 1024];
    return r;
  endfunction
  function automatic logic [15:0] rot16(input logic [15:0] d, input int k);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = d[(i + k) % 16];
    return r;
  endfunction
  function automatic logic [1023:0] rnd();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
`ifdef PERMUTE_PIPE_INVERSE_EN
  task automatic xfer(input logic [1023:0] d, input logic [9:0] s, input logic inv,
                      output logic [1023:0] od, output int lat);
    a_in_data = d; a_in_shift = s; a_in_inverse = inv; a_in_tag = 8'h77; a_in_valid = 1'b1;
    od = 'x; lat = -1;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      if (a_out_valid) begin od = a_out_data; lat = c; end
      else @(negedge clk);
    end
    @(negedge clk);
  endtask
`endif
  logic [1023:0] e1, v2 [4], v3 [6], e3 [6], x, y, z;
  int sh2 [4] = '{0, 513, 1023, 512};
  int s3 [6];
  int acc, got, lat;
  bit take, seen;
  logic [15:0] bd;
  initial begin
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_data = '0; a_in_shift = '0; a_in_tag = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_data = '0; b_in_shift = '0; b_in_tag = '0;
`ifdef PERMUTE_PIPE_INVERSE_EN
    a_in_inverse = 1'b0; b_in_inverse = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 1024'(a_out_valid), 1024'(0));
    chk("reset_in_ready", 1024'(a_in_ready), 1024'(1));
    chk("reset_b_out_valid", 1024'(b_out_valid), 1024'(0));
    // single set bit rotated right by one lands in the top bit after five stages
    a_in_data = 1024'(1); a_in_shift = 10'd1; a_in_tag = 8'h5A; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("latency_not_early", 1024'(a_out_valid), 1024'(0));
    @(negedge clk);
    e1 = '0; e1[1023] = 1'b1;
    chk("latency_valid", 1024'(a_out_valid), 1024'(1));
    chk("single_bit_data", a_out_data, e1);
    chk("single_bit_tag", 1024'(a_out_tag), 1024'(8'h5A));
    @(negedge clk);
    chk("single_consumed", 1024'(a_out_valid), 1024'(0));
    for (int k = 0; k < 4; k++) v2[k] = rnd();
    for (int c = 0; c < 10; c++) begin
      if (c >= 5 && c <= 8) begin
        chk("b2b_valid", 1024'(a_out_valid), 1024'(1));
        chk("b2b_data", a_out_data, rot_ref(v2[c-5], sh2[c-5]));
        chk("b2b_tag", 1024'(a_out_tag), 1024'(c - 4));
      end
      if (c == 9) chk("b2b_drained", 1024'(a_out_valid), 1024'(0));
      a_in_valid = c < 4;
      if (c < 4) begin a_in_data = v2[c]; a_in_shift = 10'(sh2[c]); a_in_tag = 8'(c + 1); end
      @(negedge clk);
    end
    // stall with the input kept busy: exactly five accepts fill the pipe
    for (int k = 0; k < 6; k++) begin
      v3[k] = rnd(); s3[k] = $urandom_range(0, 1023); e3[k] = rot_ref(v3[k], s3[k]);
    end
    a_out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 10; c++) begin
      if (c >= 5) begin
        chk("stall_valid", 1024'(a_out_valid), 1024'(1));
        chk("stall_data_stable", a_out_data, e3[0]);
      end
      a_in_valid = 1'b1; a_in_data = v3[acc]; a_in_shift = 10'(s3[acc]); a_in_tag = 8'(16 + acc);
      #1 take = a_in_ready;
      @(negedge clk);
      if (take) acc++;
    end
    chk("stall_accepts", 1024'(acc), 1024'(5));
    chk("stall_in_ready_low", 1024'(a_in_ready), 1024'(0));
    a_out_ready = 1'b1;
    a_in_data = v3[5]; a_in_shift = 10'(s3[5]); a_in_tag = 8'(21);
    #1 chk("full_pipe_in_ready", 1024'(a_in_ready), 1024'(1));
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (a_out_valid) begin
        if (got < 6) begin
          chk("drain_data", a_out_data, e3[got]);
          chk("drain_tag", 1024'(a_out_tag), 1024'(16 + got));
        end
        got++;
      end
      @(negedge clk);
      a_in_valid = 1'b0;
    end
    chk("drain_count", 1024'(got), 1024'(6));
    chk("drain_empty", 1024'(a_out_valid), 1024'(0));
    // reset with three vectors in flight
    for (int c = 0; c < 3; c++) begin
      a_in_valid = 1'b1; a_in_data = v3[c]; a_in_shift = 10'(s3[c]); a_in_tag = 8'(c);
      @(negedge clk);
    end
    a_in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 1024'(a_out_valid), 1024'(0));
    chk("midrst_in_ready", 1024'(a_in_ready), 1024'(1));
    seen = 1'b0;
    repeat (10) begin
      if (a_out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("midrst_no_stale", 1024'(seen), 1024'(0));
    // DIM=16, B=3: two stages, last resolves one bit; all shifts streamed
    bd = 16'hB2E1;
    for (int c = 0; c < 18; c++) begin
      if (c == 1) chk("b_latency_not_early", 1024'(b_out_valid), 1024'(0));
      if (c >= 2) begin
        chk("b_valid", 1024'(b_out_valid), 1024'(1));
        chk("b_data", 1024'(b_out_data), 1024'(rot16(bd, c - 2)));
        chk("b_tag", 1024'(b_out_tag), 1024'(c - 2));
      end
      b_in_valid = c < 16; b_in_data = bd; b_in_shift = 4'(c); b_in_tag = 8'(c);
      @(negedge clk);
    end
    chk("b_drained", 1024'(b_out_valid), 1024'(0));
`ifdef PERMUTE_PIPE_INVERSE_EN
    x = rnd();
    xfer(x, 10'd5, 1'b0, y, lat);
    chk("inv_fwd_latency", 1024'(lat), 1024'(5));
    chk("inv_fwd_data", y, rot_ref(x, 5));
    xfer(y, 10'd5, 1'b1, z, lat);
    chk("inv_back_latency", 1024'(lat), 1024'(5));
    chk("inv_recovered", z, x);
    xfer(x, 10'd0, 1'b1, z, lat);
    chk("inv_zero_passthrough", z, x);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
